svm_win_array: RTL and testbench

Parametrised systolic linear-SVM window scorer: consumes a raster stream of scalar Q(FEA_I.FEA_F) block features and emits one signed score per ROW×COL sliding window. Score = bias + Σ w[i][j]·x[r+i][c+j]. It uses COL-PE row chains joined by (FRAME_W−COL)-deep line buffers, a register-file coefficient store, a programmable decision threshold and end-of-frame signalling. It sits between the HOG normaliser output and the detection/NMS stage.

---
 rtl/svm_win_array.sv | 236 +++++++++++++++++++++++
 tb/tb_svm_win_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_win_array.sv
// -----------------------------------------------------------------------------
// svm_win_array
//
// Systolic linear-SVM window scorer. A raster stream of signed Q(FEA_I.FEA_F)
// block features is folded into one signed score per ROW x COL sliding window:
//   score = bias + sum_{i,j} w[i][j] * x[r+i][c+j]
// Each of the ROW PE rows is a COL-deep chain of multiply-accumulate registers.
// Consecutive rows are joined by (FRAME_W-COL)-deep line buffers, so the
// partial sum of row i-1 re-enters row i exactly one feature-map row later.
// Requires ROW >= 2 and FRAME_W > COL.
//
// Optional feature (compile-time macro SVM_SAT_EN):
//   defined   : the scaled product and every accumulation clamp to the ACC_W
//               signed range.
//   undefined : two's-complement wrap (truncate to ACC_W); no clamp logic.
//
// Stream semantics: i_valid qualifies fea/i_sof for one cycle; there is no
// backpressure, so every cycle with i_valid=1 consumes one feature. o_valid
// is a one-cycle pulse qualifying score/sw_id/o_eof; the consumer must accept
// it in that cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   coef_we/addr/data        coefficient file write (addr = i*COL+j)
//   bias, b_load             bias register load
//   thr                      signed decision threshold (live)
//   i_valid, i_sof, fea      feature stream in
//   o_valid, score, sw_id    window score out, raster window index
//   o_eof                    marks the last window of a frame
//   is_person                score >= thr (combinational)
// -----------------------------------------------------------------------------
module svm_win_array #(
    parameter int FEA_I   = 4,
    parameter int FEA_F   = 8,
    parameter int ACC_G   = 4,
    parameter int ROW     = 15,
    parameter int COL     = 7,
    parameter int FRAME_W = 40,
    parameter int FRAME_H = 30,
    parameter int SW_W    = 11,
    localparam int FEA_W  = FEA_I + FEA_F,
    localparam int ACC_W  = FEA_W + ACC_G,
    localparam int CA_W   = (ROW * COL > 1) ? $clog2(ROW * COL) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [CA_W-1:0]         coef_addr,
    input  logic signed [FEA_W-1:0] coef_data,
    input  logic signed [FEA_W-1:0] bias,
    input  logic                    b_load,
    input  logic signed [ACC_W-1:0] thr,
    input  logic                    i_valid,
    input  logic                    i_sof,
    input  logic signed [FEA_W-1:0] fea,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] score,
    output logic                    is_person,
    output logic [SW_W-1:0]         sw_id,
    output logic                    o_eof
);

    localparam int NCOEF = ROW * COL;
    localparam int LB_D  = FRAME_W - COL;
    localparam int PRD_W = 2 * FEA_W;
    // Product workspace one bit wider than both the full product and ACC_W,
    // so the clamp comparison below never overflows.
    localparam int EXT_W = ((PRD_W > ACC_W) ? PRD_W : ACC_W) + 1;
    localparam int RW    = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int CW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int NWX   = FRAME_W - COL + 1;

    localparam logic [RW-1:0] R_LAST = RW'(FRAME_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(FRAME_W - 1);
    localparam logic [RW-1:0] R_OFF  = RW'(ROW - 1);
    localparam logic [CW-1:0] C_OFF  = CW'(COL - 1);

`ifdef SVM_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] EXT_MAX = EXT_W'(ACC_MAX);
    localparam logic signed [EXT_W-1:0] EXT_MIN = EXT_W'(ACC_MIN);
`endif

    // Signed product, floor-shifted back to the feature's binary point, then
    // fitted into the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_fit(
        input logic signed [FEA_W-1:0] w,
        input logic signed [FEA_W-1:0] x
    );
        logic signed [EXT_W-1:0] a;
        logic signed [EXT_W-1:0] b;
        logic signed [EXT_W-1:0] p;
        a = EXT_W'(w);
        b = EXT_W'(x);
        p = (a * b) >>> FEA_F;
`ifdef SVM_SAT_EN
        if (p > EXT_MAX)      mul_fit = ACC_MAX;
        else if (p < EXT_MIN) mul_fit = ACC_MIN;
        else                  mul_fit = ACC_W'(p);
`else
        mul_fit = ACC_W'(p);
`endif
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_fit(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef SVM_SAT_EN
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        // Overflow shows as disagreement between the guard bit and the MSB.
        if (s[ACC_W] != s[ACC_W-1]) acc_fit = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else                        acc_fit = ACC_W'(s);
`else
        acc_fit = a + b;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Coefficient file and bias register (not reset)
    // ------------------------------------------------------------------
    logic signed [FEA_W-1:0] coef_mem [NCOEF];
    logic signed [FEA_W-1:0] bias_q;

    always_ff @(posedge clk) begin
        if (coef_we && (32'(coef_addr) < NCOEF)) coef_mem[coef_addr] <= coef_data;
        if (b_load) bias_q <= bias;
    end

    // ------------------------------------------------------------------
    // PE array and line buffers
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] pe_q  [ROW][COL];
    logic signed [ACC_W-1:0] pe_in [ROW][COL];
    logic signed [ACC_W-1:0] lb_q  [ROW-1][LB_D];

    for (genvar gi = 0; gi < ROW; gi++) begin : g_row
        for (genvar gj = 0; gj < COL; gj++) begin : g_col
            if (gj > 0) begin : g_chain
                assign pe_in[gi][gj] = pe_q[gi][gj-1];
            end else if (gi > 0) begin : g_wrap
                assign pe_in[gi][gj] = lb_q[gi-1][LB_D-1];
            end else begin : g_bias
                assign pe_in[gi][gj] = ACC_W'(bias_q);
            end
        end
    end

    // The coefficient read here sees the pre-write value when coef_we and
    // i_valid coincide, because the file updates with the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ROW; i++)
                for (int j = 0; j < COL; j++)
                    pe_q[i][j] <= '0;
        end else if (i_valid) begin
            for (int i = 0; i < ROW; i++)
                for (int j = 0; j < COL; j++)
                    pe_q[i][j] <= acc_fit(pe_in[i][j], mul_fit(coef_mem[i*COL+j], fea));
        end
    end

    // Contents are stale after reset; the window-validity rule guarantees a
    // full refill before any of them contribute to a flagged score.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            for (int i = 0; i < ROW - 1; i++) begin
                lb_q[i][0] <= pe_q[i][COL-1];
                for (int k = 1; k < LB_D; k++)
                    lb_q[i][k] <= lb_q[i][k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster position and window bookkeeping
    // ------------------------------------------------------------------
    logic [RW-1:0]   r_q, cur_r, nxt_r;
    logic [CW-1:0]   c_q, cur_c, nxt_c;
    logic            win_hit, win_eof;
    logic [SW_W-1:0] win_id;

    always_comb begin
        // i_sof pins the feature being consumed to (0,0) before any test.
        cur_r   = i_sof ? '0 : r_q;
        cur_c   = i_sof ? '0 : c_q;
        nxt_r   = cur_r;
        nxt_c   = cur_c + CW'(1);
        if (cur_c == C_LAST) begin
            nxt_c = '0;
            nxt_r = (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
        end
        win_hit = i_valid && (cur_r >= R_OFF) && (cur_c >= C_OFF);
        win_eof = (cur_r == R_LAST) && (cur_c == C_LAST);
        win_id  = SW_W'(cur_r - R_OFF) * SW_W'(NWX) + SW_W'(cur_c - C_OFF);
    end

    // Stage 1 (window's bottom-right edge): the PE array completes the sum and
    // the window tag is latched. Stage 2 (next edge): outputs are registered.
    logic            win_q;
    logic            win_eof_q;
    logic [SW_W-1:0] win_id_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q       <= '0;
            c_q       <= '0;
            win_q     <= 1'b0;
            win_eof_q <= 1'b0;
            win_id_q  <= '0;
            o_valid   <= 1'b0;
            o_eof     <= 1'b0;
            score     <= '0;
            sw_id     <= '0;
        end else begin
            if (i_valid) begin
                r_q <= nxt_r;
                c_q <= nxt_c;
            end
            win_q     <= win_hit;
            win_eof_q <= win_eof;
            win_id_q  <= win_id;
            o_valid   <= win_q;
            o_eof     <= win_q && win_eof_q;
            if (win_q) begin
                score <= pe_q[ROW-1][COL-1];
                sw_id <= win_id_q;
            end
        end
    end

    assign is_person = (score >= thr);

endmodule

// File: tb/tb_svm_win_array.sv
// -----------------------------------------------------------------------------
// tb_svm_win_array
//
// Bench for svm_win_array at ROW=2, COL=2, FRAME_W=4, FRAME_H=3, Q4.8,
// ACC_W=16. A small reference (dot product over a frame image, applied in
// window order bias + w00*x + w01*x + w10*x + w11*x) fills an expected queue;
// a negedge monitor pops it on every o_valid. Directed frames add
// hand-computed score checks. Honors SVM_SAT_EN for the clamp behaviour.
// -----------------------------------------------------------------------------
module tb_svm_win_array;

    localparam int FEA_I = 4, FEA_F = 8, ACC_G = 4;
    localparam int ROW = 2, COL = 2, FRAME_W = 4, FRAME_H = 3, SW_W = 4;
    localparam int FEA_W = FEA_I + FEA_F;
    localparam int ACC_W = FEA_W + ACC_G;
    localparam int EW    = 1 + SW_W + ACC_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                    coef_we = 1'b0;
    logic [1:0]              coef_addr = '0;
    logic signed [FEA_W-1:0] coef_data = '0;
    logic signed [FEA_W-1:0] bias = '0;
    logic                    b_load = 1'b0;
    logic signed [ACC_W-1:0] thr = '0;
    logic                    i_valid = 1'b0;
    logic                    i_sof = 1'b0;
    logic signed [FEA_W-1:0] fea = '0;
    logic                    o_valid;
    logic signed [ACC_W-1:0] score;
    logic                    is_person;
    logic [SW_W-1:0]         sw_id;
    logic                    o_eof;

    svm_win_array #(
        .FEA_I(FEA_I), .FEA_F(FEA_F), .ACC_G(ACC_G), .ROW(ROW), .COL(COL),
        .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .SW_W(SW_W)
    ) dut (
        .clk(clk), .rst(rst),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .bias(bias), .b_load(b_load), .thr(thr),
        .i_valid(i_valid), .i_sof(i_sof), .fea(fea),
        .o_valid(o_valid), .score(score), .is_person(is_person),
        .sw_id(sw_id), .o_eof(o_eof)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    int w_m [4];
    int bias_m = 0;
    int img [FRAME_H][FRAME_W];
    int mr = 0, mc = 0;
    logic [EW-1:0] exp_q [$];

    function automatic int fit16(input int v);
        logic signed [ACC_W-1:0] t;
`ifdef SVM_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = 16'(v);
        return int'(t);
`endif
    endfunction

    function automatic int model_mul(input int w, input int x);
        int p;
        p = (w * x) >>> FEA_F;
        return fit16(p);
    endfunction

    function automatic int model_score(input int r, input int c);
        int s;
        s = bias_m;
        for (int i = 0; i < ROW; i++)
            for (int j = 0; j < COL; j++)
                s = fit16(s + model_mul(w_m[i*COL+j], img[r-ROW+1+i][c-COL+1+j]));
        return s;
    endfunction

    // ---------------- scoreboard monitor ----------------
    int n_win = 0;
    int obs_score [$];
    int obs_id [$];
    int obs_person [$];

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && o_valid) begin
            n_win++;
            obs_score.push_back(int'(score));
            obs_id.push_back(int'(sw_id));
            obs_person.push_back(int'(is_person));
            if (exp_q.size() == 0) begin
                chk("unexpected_window", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("score", int'(score), int'($signed(e[ACC_W-1:0])));
                chk("sw_id", int'(sw_id), int'(e[ACC_W +: SW_W]));
                chk("o_eof", int'(o_eof), int'(e[EW-1]));
                chk("is_person", int'(is_person),
                    int'($signed(e[ACC_W-1:0]) >= thr));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0; i_sof = 1'b0; coef_we = 1'b0; b_load = 1'b0;
        end
    endtask

    // One feature; optionally a coefficient write in the same cycle. The
    // model scores with the pre-write weight, then applies the write.
    task automatic feed(input int x, input bit sof, input bit we = 1'b0,
                        input int wa = 0, input int wd = 0);
        logic [EW-1:0] e;
        int s;
        @(negedge clk);
        i_valid = 1'b1; i_sof = sof; fea = FEA_W'(x); b_load = 1'b0;
        coef_we = we; coef_addr = 2'(wa); coef_data = FEA_W'(wd);
        if (sof) begin mr = 0; mc = 0; end
        img[mr][mc] = x;
        if (mr >= ROW - 1 && mc >= COL - 1) begin
            s = model_score(mr, mc);
            e = {(mr == FRAME_H - 1 && mc == FRAME_W - 1),
                 SW_W'((mr - ROW + 1) * (FRAME_W - COL + 1) + (mc - COL + 1)),
                 ACC_W'(s)};
            exp_q.push_back(e);
        end
        if (we) w_m[wa] = wd;
        if (mc == FRAME_W - 1) begin
            mc = 0;
            mr = (mr == FRAME_H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        i_valid = 1'b0; i_sof = 1'b0; b_load = 1'b0;
        coef_we = 1'b1; coef_addr = 2'(a); coef_data = FEA_W'(d);
        w_m[a] = d;
        idle(1);
    endtask

    task automatic set_bias(input int b);
        @(negedge clk);
        i_valid = 1'b0; coef_we = 1'b0;
        b_load = 1'b1; bias = FEA_W'(b);
        bias_m = b;
        idle(1);
    endtask

    task automatic frame_const(input int x);
        for (int k = 0; k < FRAME_W * FRAME_H; k++) feed(x, k == 0);
    endtask

    task automatic drain(input string tag, input int n_exp);
        idle(4);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_window_count"}, n_win, n_exp);
    endtask

    task automatic new_run();
        n_win = 0;
        obs_score.delete();
        obs_id.delete();
        obs_person.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_sw_id", int'(sw_id), 0);
        chk("rst_o_eof", int'(o_eof), 0);
        rst = 1'b1;
        idle(1);

        // Basic: all weights 1.0, features 1.0 -> 4.0 = 1024 per window.
        for (int a = 0; a < 4; a++) write_coef(a, 256);
        set_bias(0);
        thr = '0;
        new_run();
        frame_const(256);
        drain("basic", 6);
        if (obs_score.size() == 6) begin
            chk("basic_first_score", obs_score[0], 1024);
            chk("basic_last_score", obs_score[5], 1024);
            chk("basic_first_id", obs_id[0], 0);
            chk("basic_last_id", obs_id[5], 5);
        end else chk("basic_capture", obs_score.size(), 6);

        // Weights {1,0,0,-1}; features (r*4+c)*0.5 keep the largest entry
        // (11 -> 1408) inside Q4.8, so every window scores -5*128 = -640.
        write_coef(0, 256); write_coef(1, 0); write_coef(2, 0); write_coef(3, -256);
        thr = '0;
        new_run();
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < FRAME_W; c++)
                feed((r * 4 + c) * 128, (r == 0 && c == 0));
        drain("weights_thr0", 6);
        if (obs_score.size() == 6) begin
            chk("weights_score", obs_score[2], -640);
            chk("weights_person_thr0", obs_person[2], 0);
        end else chk("weights_capture", obs_score.size(), 6);
        thr = -16'sd640;
        new_run();
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < FRAME_W; c++)
                feed((r * 4 + c) * 128, (r == 0 && c == 0));
        drain("weights_thrneg", 6);
        if (obs_person.size() == 6) chk("weights_person_thr_eq", obs_person[4], 1);
        else chk("weights_capture2", obs_person.size(), 6);

        // Gaps and mid-frame sof: 7 features (two windows form at features
        // 5 and 6), then i_sof on feature 7 restarts a full frame.
        for (int a = 0; a < 4; a++) write_coef(a, int'($urandom_range(0, 1023)) - 512);
        set_bias(int'($urandom_range(0, 511)) - 256);
        thr = '0;
        new_run();
        for (int k = 0; k < 7; k++) begin
            idle(int'($urandom_range(0, 2)));
            feed(int'($urandom_range(0, 1023)) - 512, k == 0);
        end
        for (int k = 0; k < FRAME_W * FRAME_H; k++) begin
            idle(int'($urandom_range(0, 2)));
            feed(int'($urandom_range(0, 1023)) - 512, k == 0);
        end
        drain("gaps_sof", 8);

        // Saturation: 7.0*7.0 = 49.0 per product, four of them overflow Q16.
        for (int a = 0; a < 4; a++) write_coef(a, 1792);
        set_bias(0);
        new_run();
        frame_const(1792);
        drain("saturation", 6);
        if (obs_score.size() == 6) begin
`ifdef SVM_SAT_EN
            chk("sat_score", obs_score[0], 32767);
`else
            chk("wrap_score", obs_score[0], -15360);
`endif
        end else chk("sat_capture", obs_score.size(), 6);

        // Reset mid-frame right after a window's bottom-right feature.
        for (int a = 0; a < 4; a++) write_coef(a, 256);
        new_run();
        for (int k = 0; k < 6; k++) feed(256, k == 0);
        @(negedge clk);
        i_valid = 1'b0; i_sof = 1'b0; rst = 1'b0;
        exp_q.delete();
        mr = 0; mc = 0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset_o_valid", int'(o_valid), 0);
        chk("reset_score", int'(score), 0);
        for (int k = 0; k < FRAME_W * FRAME_H; k++) feed(256, 1'b0);
        drain("after_reset", 6);
        if (obs_id.size() == 6) begin
            chk("after_reset_first_id", obs_id[0], 0);
            chk("after_reset_score", obs_score[0], 1024);
        end else chk("after_reset_capture", obs_id.size(), 6);

        // Coefficient write colliding with feature 5 (window 0's last
        // product): window 0 keeps w11=1.0, later windows see w11=2.0.
        new_run();
        for (int k = 0; k < FRAME_W * FRAME_H; k++)
            feed(256, k == 0, k == 5, 3, 512);
        drain("collision", 6);
        if (obs_score.size() == 6) begin
            chk("collision_old_weight", obs_score[0], 1024);
            chk("collision_new_weight", obs_score[1], 1280);
        end else chk("collision_capture", obs_score.size(), 6);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
